// File: rtl/otter_pipe_pkg.sv
// otter_pipe_pkg: shared sequencer state encoding and pipeline bubble constant
package otter_pipe_pkg;
  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    DRAIN    = 2'd2,
    HALTED   = 2'd3
  } pipe_state_t;
  localparam logic [31:0] NOP_IR = 32'h0000_0013;
endpackage

// File: rtl/sat_counter.sv
// sat_counter: event counter that sticks at all-ones
module sat_counter #(
  parameter int W = 16
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         inc,
  output logic [W-1:0] cnt
);
  always_ff @(posedge CLK) cnt <= RST ? '0 : (inc && !(&cnt)) ? cnt + 1'b1 : cnt;
endmodule

// File: rtl/otter_pipe_ctrl.sv
// otter_pipe_ctrl: stage enables/flushes for stalls, squashes, memory waits and halt drain
module otter_pipe_ctrl
  import otter_pipe_pkg::*;
#(
  parameter int CNT_W        = 16,
  parameter int MEM_TIMEOUT  = 64,
  parameter int DRAIN_CYCLES = 3
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [4:0]       rs1_D,
  input  logic [4:0]       rs2_D,
  input  logic             uses_rs1_D,
  input  logic             uses_rs2_D,
  input  logic [4:0]       rd_E,
  input  logic             memRead_E,
  input  logic             pcSrc_E,
  input  logic             mem_busy,
  input  logic             ext_halt,
  output logic             pc_en,
  output logic             fd_en,
  output logic             de_en,
  output logic             em_en,
  output logic             mw_en,
  output logic             fd_flush,
  output logic             de_flush,
  output logic             halted,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [CNT_W-1:0] wait_cnt
);
  localparam int DW = $clog2(DRAIN_CYCLES + 1);
  localparam int EW = $clog2(MEM_TIMEOUT + 1);
  localparam logic [DW-1:0] DLAST = DW'(DRAIN_CYCLES - 1);
  localparam logic [EW-1:0] ETO = EW'(MEM_TIMEOUT);
  pipe_state_t state, ret_state, eff;
  logic [DW-1:0] drain_cnt;
  logic [EW-1:0] ep, ep_nxt;
  logic freeze, squash, lu, hold;
  // a finished memory wait resumes the interrupted state's rules in the same cycle
  assign eff    = (state == MEM_WAIT && !mem_busy) ? ret_state : state;
  assign freeze = mem_busy && state != HALTED;
  assign squash = !freeze && (eff == RUN || eff == DRAIN) && pcSrc_E;
  assign lu     = !freeze && !squash && eff == RUN && memRead_E && rd_E != 5'd0 &&
                  ((uses_rs1_D && rs1_D == rd_E) || (uses_rs2_D && rs2_D == rd_E));
  assign hold   = lu || (!freeze && !squash && eff == DRAIN) || state == HALTED;
  assign pc_en    = RST || !(freeze || hold);
  assign fd_en    = pc_en;
  assign de_en    = RST || !freeze;
  assign em_en    = de_en;
  assign mw_en    = de_en;
  assign fd_flush = !RST && squash;
  assign de_flush = !RST && (squash || hold);
  assign halted   = state == HALTED;
  assign ep_nxt   = (ep == ETO) ? ep : ep + 1'b1;
  always_ff @(posedge CLK) begin
    if (RST) begin
      state       <= RUN;
      ret_state   <= RUN;
      drain_cnt   <= '0;
      ep          <= '0;
      mem_timeout <= 1'b0;
    end else if (freeze) begin
      state <= MEM_WAIT;
      if (state != MEM_WAIT) ret_state <= eff;
      ep <= ep_nxt;
      if (ep_nxt == ETO) mem_timeout <= 1'b1;
    end else begin
      ep <= '0;
      case (eff)
        RUN: if (ext_halt) begin
          state     <= DRAIN;
          drain_cnt <= '0;
        end else state <= RUN;
        DRAIN: if (!ext_halt) begin
          state     <= RUN;
          drain_cnt <= '0;
        end else if (squash) begin
          state     <= DRAIN;
          drain_cnt <= '0;
        end else if (drain_cnt == DLAST) begin
          state     <= HALTED;
        end else begin
          state     <= DRAIN;
          drain_cnt <= drain_cnt + 1'b1;
        end
        HALTED: state <= ext_halt ? HALTED : RUN;
        default: state <= RUN;
      endcase
    end
  end
  sat_counter #(.W(CNT_W)) u_stall (.CLK(CLK), .RST(RST), .inc(lu),     .cnt(stall_cnt));
  sat_counter #(.W(CNT_W)) u_flush (.CLK(CLK), .RST(RST), .inc(squash), .cnt(flush_cnt));
  sat_counter #(.W(CNT_W)) u_wait  (.CLK(CLK), .RST(RST), .inc(freeze), .cnt(wait_cnt));
endmodule

// File: tb/tb_otter_pipe_ctrl.sv
// tb_otter_pipe_ctrl: scoreboard bench for the pipeline sequencer
module tb_otter_pipe_ctrl;
  localparam int CW = 4;
  localparam logic [7:0] NORM = 8'b11111_00_0;
  localparam logic [7:0] FRZ  = 8'b00000_00_0;
  localparam logic [7:0] SQ   = 8'b11111_11_0;
  localparam logic [7:0] BUB  = 8'b00111_01_0;
  localparam logic [7:0] HLT  = 8'b00111_01_1;
  logic CLK = 1'b0, RST = 1'b1;
  logic [4:0] rs1_D = '0, rs2_D = '0, rd_E = '0;
  logic uses_rs1_D = 0, uses_rs2_D = 0, memRead_E = 0, pcSrc_E = 0, mem_busy = 0, ext_halt = 0;
  logic pc_en, fd_en, de_en, em_en, mw_en, fd_flush, de_flush, halted, mem_timeout;
  logic [CW-1:0] stall_cnt, flush_cnt, wait_cnt;
  logic [7:0] sb[$];
  int checks = 0, errors = 0;
  otter_pipe_ctrl #(.CNT_W(CW), .MEM_TIMEOUT(64), .DRAIN_CYCLES(3)) dut (
    .CLK(CLK), .RST(RST), .rs1_D(rs1_D), .rs2_D(rs2_D), .uses_rs1_D(uses_rs1_D),
    .uses_rs2_D(uses_rs2_D), .rd_E(rd_E), .memRead_E(memRead_E), .pcSrc_E(pcSrc_E),
    .mem_busy(mem_busy), .ext_halt(ext_halt), .pc_en(pc_en), .fd_en(fd_en), .de_en(de_en),
    .em_en(em_en), .mw_en(mw_en), .fd_flush(fd_flush), .de_flush(de_flush), .halted(halted),
    .mem_timeout(mem_timeout), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .wait_cnt(wait_cnt)
  );
  always #5 CLK = ~CLK;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h at %0t", tag, obs, exp, $time);
    end
  endtask
  task automatic step(input logic [7:0] exp);
    sb.push_back(exp);
    @(posedge CLK);
    #1;
  endtask
  task automatic clr();
    {rs1_D, rs2_D, rd_E} = '0;
    {uses_rs1_D, uses_rs2_D, memRead_E, pcSrc_E, mem_busy} = '0;
  endtask
  always @(negedge CLK) if (sb.size() != 0)
    chk("ctl", {pc_en, fd_en, de_en, em_en, mw_en, fd_flush, de_flush, halted}, sb.pop_front());
  initial begin
    @(posedge CLK);
    #1;
    step(NORM);
    step(NORM);
    RST = 0;
    chk("rst_stall", stall_cnt, 0);
    chk("rst_to", mem_timeout, 0);
    memRead_E = 1; rd_E = 5; uses_rs1_D = 1; rs1_D = 5;
    step(BUB);
    memRead_E = 0;
    step(NORM);
    chk("lu_stall", stall_cnt, 1);
    memRead_E = 1; rd_E = 0; rs1_D = 0;
    step(NORM);
    uses_rs1_D = 0; uses_rs2_D = 1; rd_E = 7; rs2_D = 7;
    step(BUB);
    uses_rs2_D = 0;
    step(NORM);
    chk("lu_rs2", stall_cnt, 2);
    uses_rs1_D = 1; rs1_D = 5; rd_E = 5; pcSrc_E = 1;
    step(SQ);
    clr();
    chk("sq_flush", flush_cnt, 1);
    chk("sq_nostall", stall_cnt, 2);
    mem_busy = 1;
    repeat (5) step(FRZ);
    mem_busy = 0; memRead_E = 1; rd_E = 9; uses_rs1_D = 1; rs1_D = 9;
    step(BUB);
    clr();
    chk("wait5", wait_cnt, 5);
    chk("to5", mem_timeout, 0);
    chk("lu_after_wait", stall_cnt, 3);
    mem_busy = 1;
    repeat (70) step(FRZ);
    mem_busy = 0;
    step(NORM);
    chk("wait_sat", wait_cnt, 15);
    chk("to70", mem_timeout, 1);
    repeat (3) step(NORM);
    chk("to_sticky", mem_timeout, 1);
    ext_halt = 1;
    step(NORM);
    repeat (3) step(BUB);
    step(HLT);
    mem_busy = 1; pcSrc_E = 1;
    step(HLT);
    clr();
    chk("hlt_noflush", flush_cnt, 1);
    ext_halt = 0;
    step(HLT);
    step(NORM);
    ext_halt = 1;
    step(NORM);
    step(BUB);
    mem_busy = 1;
    repeat (4) step(FRZ);
    mem_busy = 0;
    step(BUB);
    step(BUB);
    step(HLT);
    ext_halt = 0;
    step(HLT);
    step(NORM);
    ext_halt = 1;
    step(NORM);
    step(BUB);
    pcSrc_E = 1;
    step(SQ);
    pcSrc_E = 0;
    repeat (3) step(BUB);
    step(HLT);
    chk("drain_sq", flush_cnt, 2);
    ext_halt = 0;
    step(HLT);
    ext_halt = 1;
    step(NORM);
    step(BUB);
    ext_halt = 0;
    step(BUB);
    step(NORM);
    mem_busy = 1;
    repeat (2) step(FRZ);
    RST = 1;
    step(NORM);
    RST = 0; mem_busy = 0;
    step(NORM);
    chk("rst_wait", wait_cnt, 0);
    chk("rst_stall2", stall_cnt, 0);
    chk("rst_flush", flush_cnt, 0);
    chk("rst_to2", mem_timeout, 0);
    chk("sb_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/otter_pipe_ctrl.md
Name: otter_pipe_ctrl

Overview:
Central pipeline sequencer for the 5-stage pipelined OTTER core (F/D/E/M/W). It generates the per-stage register enables and flushes for:
- load-use stalls;
- taken branch/jump squashes;
- multi-cycle data-memory waits;
- an external halt/drain request.

It sits beside the forwarding unit and drives the PC and the FD/DE/EM/MW pipeline-register controls. It also keeps saturating event counters for performance debug.

Parameters:
CNT_W, 16, width of saturating event counters
MEM_TIMEOUT, 64, wait cycles in one MEM_WAIT episode after which mem_timeout sets
DRAIN_CYCLES, 3, bubble cycles needed to empty DE/EM/MW before HALTED

Ports:
CLK  in  1  clock; all state updates on rising edge
RST  in  1  synchronous reset, active-high
rs1_D  in  5  rs1 of instruction in decode (FD.IR[19:15])
rs2_D  in  5  rs2 of instruction in decode (FD.IR[24:20])
uses_rs1_D  in  1  decode instruction reads rs1
uses_rs2_D  in  1  decode instruction reads rs2
rd_E  in  5  destination of instruction in execute
memRead_E  in  1  execute instruction is a load
pcSrc_E  in  1  taken branch/jump resolved in execute this cycle
mem_busy  in  1  data memory not ready; M-stage access incomplete
ext_halt  in  1  level halt request (debug)
pc_en, fd_en, de_en, em_en, mw_en  out  1 each  stage register load enables
fd_flush, de_flush  out  1 each  load bubble (all-zero IR/controls) at next edge; overrides en
halted  out  1  pipeline empty and stopped
mem_timeout  out  1  sticky: a MEM_WAIT episode exceeded MEM_TIMEOUT
stall_cnt, flush_cnt, wait_cnt  out  CNT_W each  load-use stalls, taken squashes, total MEM_WAIT cycles (saturating)

Behaviour:
- Clocking/reset: single clock CLK; RST synchronous, active-high.
- Reset values: state=RUN, drain_cnt=0, ret_state=RUN, all counters=0, mem_timeout=0, halted=0.
- While RST=1, all *_en=1 and all *_flush=0.
- States: RUN, MEM_WAIT, DRAIN, HALTED. Outputs are combinational from state and inputs; zero-latency hazard response.
- Effective state eff: if state=MEM_WAIT and mem_busy=0, eff=ret_state; otherwise eff=state.
- Defaults: all en=1, all flush=0.
- Priority 1, freeze: eff in {RUN, DRAIN} and mem_busy=1, or state=MEM_WAIT with mem_busy=1.
  - All en=0, all flush=0.
  - Next state MEM_WAIT; ret_state captures eff on entry.
  - wait_cnt increments each frozen cycle.
  - The episode counter reaching MEM_TIMEOUT sets mem_timeout.
- Priority 2, squash (eff in {RUN, DRAIN}, pcSrc_E=1):
  - pc_en=1, fd_flush=1, de_flush=1.
  - flush_cnt increments. Load-use is ignored that cycle.
- Priority 3, load-use (eff=RUN only):
  - Condition: memRead_E=1, rd_E!=0, and (uses_rs1_D and rs1_D==rd_E) or (uses_rs2_D and rs2_D==rd_E).
  - Action: pc_en=0, fd_en=0, de_flush=1; stall_cnt increments. Exactly one bubble per load.
- RUN to DRAIN:
  - Transition when ext_halt=1 and no freeze; RUN rules still apply that cycle.
  - DRAIN entry clears drain_cnt.
- DRAIN:
  - Non-freeze, non-squash cycles: pc_en=0, fd_en=0, de_flush=1. FD keeps its instruction.
  - drain_cnt increments on each non-frozen cycle.
  - drain_cnt reaching DRAIN_CYCLES-1 gives next state HALTED.
  - ext_halt=0 gives next state RUN (abort; drain_cnt cleared).
  - A squash in DRAIN restarts drain_cnt at 0.
- HALTED:
  - halted=1, pc_en=0, fd_en=0, de_flush=1, em_en=mw_en=1.
  - mem_busy and pcSrc_E are ignored.
  - ext_halt=0 gives next state RUN; halted drops the cycle after.
- Counters saturate at 2^CNT_W-1.
- mem_timeout is cleared only by RST.
- Reset mid-MEM_WAIT or mid-DRAIN returns to RUN with the reset values above.

Decomposition:
- Shared package otter_pipe_pkg: state enum (RUN=2'd0, MEM_WAIT=2'd1, DRAIN=2'd2, HALTED=2'd3) and bubble IR constant 32'h0000_0013 (NOP).
- The three saturating counters instantiate one sub-module, sat_counter (parameter W; ports CLK, RST, inc, cnt).

Test Plan:
- Load-use hazard: lw x5 in E (memRead_E=1, rd_E=5) with add in D (uses_rs1_D=1, rs1_D=5) → one cycle of pc_en=0, fd_en=0, de_flush=1; stall_cnt=1. Same case with rd_E=0 → no stall.
- Taken branch: pcSrc_E=1 in the same cycle as a load-use match → pc_en=1, fd_flush=de_flush=1, no stall; flush_cnt=1, stall_cnt=0.
- Memory wait: mem_busy=1 for 5 cycles → all en=0 for 5 cycles, then normal; wait_cnt=5, mem_timeout=0. Repeat with 70 cycles → mem_timeout=1 and stays set.
- Halt request: ext_halt=1 from RUN → 3 DRAIN cycles with de_flush=1, then halted=1. Release ext_halt → halted=0 next cycle and pc_en=1.
- Halt interactions: mem_busy=1 during DRAIN cycle 2 for 4 cycles → drain pauses and resumes in DRAIN; halted asserts after 3 non-frozen drain cycles total. A pcSrc_E pulse mid-drain restarts drain_cnt.
- Reset mid-operation: RST asserted during MEM_WAIT → next cycle state=RUN, all counters 0, mem_timeout=0, all en=1.
